// File: rtl/reaction_timer_ctrl.sv
// Reaction-time controller: LFSR-driven random pre-stimulus delay, millisecond
// reaction counter with saturation, and a session best-time register.
module reaction_timer_ctrl #(
  parameter int TICKS_PER_MS = 10000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int MAX_COUNT    = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arm,
  input  logic        start_timer,
  input  logic        stop_timer,
  input  logic        abort,
  input  logic        clear_best,
  output logic        delay_done,
  output logic [13:0] elapsed_time,
  output logic [13:0] best_time,
  output logic        best_valid,
  output logic        timeout,
  output logic        busy
);

  localparam int              PW         = $clog2(TICKS_PER_MS);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICKS_PER_MS - 1);
  localparam logic [13:0]     MAX_CNT    = 14'(MAX_COUNT);
  localparam logic [15:0]     MIN_DLY    = 16'(MIN_DELAY_MS);
  localparam logic [15:0]     LFSR_SEED  = 16'hACE1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_ARMED,
    S_TIMING,
    S_HOLD
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [15:0]     r_lfsr;
  logic            w_lfsr_fb;
  logic [PW-1:0]   r_presc, w_presc_nxt;
  logic            w_ms_tick;
  logic [15:0]     r_ms_cnt, w_ms_cnt_nxt, w_ms_inc;
  logic [15:0]     r_target, w_target_nxt;
  logic [13:0]     r_elapsed, w_elapsed_nxt, w_el_inc;
  logic [13:0]     r_best, w_best_nxt;
  logic            r_best_valid, w_best_valid_nxt;
  logic            r_delay_done, w_delay_done_nxt;
  logic            r_timeout, w_timeout_nxt;
  logic            r_busy, w_busy_nxt;
  logic            w_arm_ok;

  // Taps 16,14,13,11 of a right-shifting Fibonacci register; the nonzero seed
  // keeps it out of the all-zero lock-up state.
  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_ms_tick = (r_presc == PRESC_LAST);
  assign w_ms_inc  = r_ms_cnt + 16'd1;
  assign w_el_inc  = r_elapsed + 14'd1;
  assign w_arm_ok  = arm && (r_state inside {S_IDLE, S_DELAY, S_HOLD});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the branches below can infer a latch.
    w_state_nxt      = r_state;
    w_presc_nxt      = w_ms_tick ? '0 : r_presc + 1'b1;
    w_ms_cnt_nxt     = r_ms_cnt;
    w_target_nxt     = r_target;
    w_elapsed_nxt    = r_elapsed;
    w_best_nxt       = r_best;
    w_best_valid_nxt = r_best_valid;
    w_delay_done_nxt = 1'b0;
    w_timeout_nxt    = 1'b0;

    if (abort) begin
      w_state_nxt   = S_IDLE;
      w_presc_nxt   = '0;
      w_ms_cnt_nxt  = '0;
      w_elapsed_nxt = '0;
    end else if (w_arm_ok) begin
      w_state_nxt   = S_DELAY;
      w_presc_nxt   = '0;
      w_ms_cnt_nxt  = '0;
      w_target_nxt  = MIN_DLY + {5'd0, r_lfsr[10:0]};
      w_elapsed_nxt = '0;
    end else begin
      unique case (r_state)
        S_DELAY: begin
          if (w_ms_tick) begin
            w_ms_cnt_nxt = w_ms_inc;
            if (w_ms_inc == r_target) begin
              w_delay_done_nxt = 1'b1;
              w_state_nxt      = S_ARMED;
            end
          end
        end
        S_ARMED: begin
          if (start_timer) begin
            w_state_nxt   = S_TIMING;
            w_presc_nxt   = '0;
            w_elapsed_nxt = '0;
          end
        end
        S_TIMING: begin
          // A stop on the same cycle as a tick freezes the pre-increment value.
          if (stop_timer) begin
            w_state_nxt = S_HOLD;
            if (!r_best_valid || (r_elapsed < r_best)) begin
              w_best_nxt       = r_elapsed;
              w_best_valid_nxt = 1'b1;
            end
          end else if (w_ms_tick) begin
            w_elapsed_nxt = w_el_inc;
            if (w_el_inc == MAX_CNT) begin
              w_timeout_nxt = 1'b1;
              w_state_nxt   = S_HOLD;
            end
          end
        end
        default: ;
      endcase
    end

    if (clear_best) begin
      w_best_nxt       = MAX_CNT;
      w_best_valid_nxt = 1'b0;
    end

    w_busy_nxt = (w_state_nxt inside {S_DELAY, S_ARMED, S_TIMING});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr       <= LFSR_SEED;
      r_presc      <= '0;
      r_ms_cnt     <= '0;
      r_target     <= '0;
      r_elapsed    <= '0;
      r_best       <= MAX_CNT;
      r_best_valid <= 1'b0;
      r_delay_done <= 1'b0;
      r_timeout    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_lfsr       <= {w_lfsr_fb, r_lfsr[15:1]};
      r_presc      <= w_presc_nxt;
      r_ms_cnt     <= w_ms_cnt_nxt;
      r_target     <= w_target_nxt;
      r_elapsed    <= w_elapsed_nxt;
      r_best       <= w_best_nxt;
      r_best_valid <= w_best_valid_nxt;
      r_delay_done <= w_delay_done_nxt;
      r_timeout    <= w_timeout_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign delay_done   = r_delay_done;
  assign elapsed_time = r_elapsed;
  assign best_time    = r_best;
  assign best_valid   = r_best_valid;
  assign timeout      = r_timeout;
  assign busy         = r_busy;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Self-checking bench for reaction_timer_ctrl: delay_done/timeout pulses are
// scoreboarded against expected cycle numbers; stop results against a best-time model.
module tb_reaction_timer_ctrl;

  localparam int TK   = 4;
  localparam int MIND = 2;
  localparam int MAXC = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm, start_timer, stop_timer, abort, clear_best;
  logic        delay_done, best_valid, timeout, busy;
  logic [13:0] elapsed_time, best_time;

  int          n_total = 0;
  int          n_bad   = 0;
  int          cyc     = 0;
  int          dd_seen = 0;
  int          to_seen = 0;
  int          exp_dd[$];
  int          exp_to[$];
  int          exp_best;
  bit          exp_valid;
  logic [15:0] m_lfsr;

  reaction_timer_ctrl #(
    .TICKS_PER_MS (TK),
    .MIN_DELAY_MS (MIND),
    .MAX_COUNT    (MAXC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arm          (arm),
    .start_timer  (start_timer),
    .stop_timer   (stop_timer),
    .abort        (abort),
    .clear_best   (clear_best),
    .delay_done   (delay_done),
    .elapsed_time (elapsed_time),
    .best_time    (best_time),
    .best_valid   (best_valid),
    .timeout      (timeout),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR: x^16+x^14+x^13+x^11+1, seeded 16'hACE1, advancing every clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Pulse monitors: each pulse pops the cycle it was predicted for.
  always @(negedge clk) begin
    if (rst_n && delay_done) begin
      dd_seen <= dd_seen + 1;
      if (exp_dd.size() == 0) check("dd_unexpected", 1, 0);
      else                    check("dd_cycle", cyc, exp_dd.pop_front());
    end
    if (rst_n && timeout) begin
      to_seen <= to_seen + 1;
      if (exp_to.size() == 0) check("to_unexpected", 1, 0);
      else                    check("to_cycle", cyc, exp_to.pop_front());
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_arm(input bit restart);
    int tgt;
    if (restart && exp_dd.size() > 0) void'(exp_dd.pop_back());
    tgt = MIND + int'(m_lfsr[10:0]);
    exp_dd.push_back(cyc + 1 + tgt * TK);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("busy_after_arm", busy, 1);
    check("elapsed_after_arm", elapsed_time, 0);
  endtask

  // Arm only when the upcoming sample gives a short delay, keeping runs brief.
  task automatic arm_small();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 5000 && !found; i++) begin
      if (m_lfsr[10:0] < 11'd64) found = 1'b1;
      else                       tick();
    end
    check("small_sample_found", found, 1);
    do_arm(1'b0);
  endtask

  task automatic wait_dd(input int budget);
    int  seen0;
    int  busy_low;
    bit  got;
    seen0    = dd_seen;
    busy_low = 0;
    got      = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      if (!busy) busy_low++;
      tick();
      got = (dd_seen != seen0);
    end
    check("dd_arrived", got, 1);
    check("busy_in_delay", busy_low, 0);
  endtask

  task automatic trial(input int m, input bit clr, input bit with_arm);
    int e;
    if (with_arm) begin
      arm_small();
      wait_dd(400);
    end
    start_timer = 1'b1;
    tick();
    start_timer = 1'b0;
    tick(m - 1);
    stop_timer = 1'b1;
    clear_best = clr;
    tick();
    stop_timer = 1'b0;
    clear_best = 1'b0;
    e = (m % TK == 0) ? m / TK - 1 : m / TK;
    if (clr) begin
      exp_best  = MAXC;
      exp_valid = 1'b0;
    end else if (!exp_valid || e < exp_best) begin
      exp_best  = e;
      exp_valid = 1'b1;
    end
    check("elapsed_stop", elapsed_time, e);
    check("best_time", best_time, exp_best);
    check("best_valid", best_valid, exp_valid);
    check("busy_hold", busy, 0);
    tick(5);
    check("elapsed_frozen", elapsed_time, e);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation ran past its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen0;
    bit got;
    rst_n = 1'b0;
    arm = 1'b0; start_timer = 1'b0; stop_timer = 1'b0; abort = 1'b0; clear_best = 1'b0;
    exp_best  = MAXC;
    exp_valid = 1'b0;
    tick(3);
    check("rst_elapsed", elapsed_time, 0);
    check("rst_best", best_time, MAXC);
    check("rst_valid", best_valid, 0);
    check("rst_dd", delay_done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick(2);

    // Full-range random delay straight out of reset.
    do_arm(1'b0);
    wait_dd(9000);
    check("busy_armed", busy, 1);

    trial(30, 1'b0, 1'b0);   // 7 ms, first best
    trial(38, 1'b0, 1'b1);   // 9 ms, best stays 7
    trial(14, 1'b0, 1'b1);   // 3 ms, new best

    // Never stop: saturate at MAX_COUNT.
    arm_small();
    wait_dd(400);
    start_timer = 1'b1;
    exp_to.push_back(cyc + 1 + MAXC * TK);
    tick();
    start_timer = 1'b0;
    seen0 = to_seen;
    got   = 1'b0;
    for (int i = 0; i < MAXC * TK + 20 && !got; i++) begin
      tick();
      got = (to_seen != seen0);
    end
    check("to_arrived", got, 1);
    check("elapsed_sat", elapsed_time, MAXC);
    check("best_after_to", best_time, exp_best);
    check("valid_after_to", best_valid, exp_valid);
    check("busy_after_to", busy, 0);
    tick(5);
    check("elapsed_sat_held", elapsed_time, MAXC);

    // Abort during the delay: the pending pulse must never appear.
    arm_small();
    tick(3);
    abort = 1'b1;
    exp_dd.delete();
    tick();
    abort = 1'b0;
    check("abort_elapsed", elapsed_time, 0);
    check("abort_busy", busy, 0);
    tick(300);
    check("abort_busy_later", busy, 0);

    // Re-arm inside DELAY: only the fresh sample's expiry counts.
    arm_small();
    tick(5);
    do_arm(1'b1);
    wait_dd(9000);

    trial(24, 1'b0, 1'b0);   // stop on tick cycle: pre-increment value 5
    trial(6,  1'b1, 1'b1);   // clear_best beats the best update
    trial(10, 1'b0, 1'b1);   // 2 ms after clear: valid again

    // Reset in the middle of timing takes effect without a clock edge.
    arm_small();
    wait_dd(400);
    start_timer = 1'b1;
    tick();
    start_timer = 1'b0;
    tick(10);
    check("pre_rst_elapsed", elapsed_time, 2);
    rst_n = 1'b0;
    #1;
    check("midrst_elapsed", elapsed_time, 0);
    check("midrst_best", best_time, MAXC);
    check("midrst_valid", best_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_dd", delay_done, 0);
    check("midrst_timeout", timeout, 0);
    exp_dd.delete();
    exp_to.delete();
    exp_best  = MAXC;
    exp_valid = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("post_rst_busy", busy, 0);

    check("dd_queue_drained", exp_dd.size(), 0);
    check("to_queue_drained", exp_to.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/reaction_timer_ctrl.md
# reaction_timer_ctrl

Sequencing and timekeeping controller for the reaction-time datapath. It produces the random pre-stimulus delay and signals its end with `delay_done`. On command it runs the millisecond reaction counter that drives `elapsed_time`, and it keeps a session best time. It sits between the reaction state machine (source of `arm`, `start_timer`, `stop_timer`) and the display/BCD path (consumer of `elapsed_time`, `best_time`, `timeout`).

## Interface
Parameters:
- `TICKS_PER_MS`, default 10000: clock cycles per millisecond tick (10 MHz clock). Must be ≥ 2.
- `MIN_DELAY_MS`, default 1000: fixed part of the random delay, in ms.
- `MAX_COUNT`, default 9999: saturation value of the reaction counter. Must fit in 14 bits.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `arm` in 1: begin a new random delay.
- `start_timer` in 1: begin reaction timing.
- `stop_timer` in 1: end reaction timing.
- `abort` in 1: cancel the current trial and return to IDLE.
- `clear_best` in 1: reset the session best time.
- `delay_done` out 1: one-cycle pulse when the random delay expires.
- `elapsed_time` out 14: current or frozen reaction time, in ms.
- `best_time` out 14: lowest completed reaction time. Reads `MAX_COUNT` when invalid.
- `best_valid` out 1: `best_time` holds a real result.
- `timeout` out 1: one-cycle pulse when the counter saturates.
- `busy` out 1: state is DELAY, ARMED or TIMING.

## Operation
- States:
  - IDLE: no trial in progress.
  - DELAY: random delay running.
  - ARMED: delay expired, waiting for `start_timer`.
  - TIMING: reaction counter running.
  - HOLD: result frozen.
- State register encoding is free.
- All outputs are registered.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Reset value 16'hACE1.
  - Advances every clock in every state.
  - Never reaches zero.
- Delay target: on an accepted `arm`, capture `target = MIN_DELAY_MS + lfsr[10:0]` using the pre-advance LFSR value. Range is MIN_DELAY_MS to MIN_DELAY_MS+2047. Target register is 16 bits wide, with no overflow at default values.
- Prescaler:
  - Counts 0..TICKS_PER_MS-1.
  - `ms_tick` fires on the cycle the count equals TICKS_PER_MS-1.
  - Cleared to 0 on accepted `arm`, on accepted `start_timer`, and on `abort`.
- Transitions and actions:
  - IDLE/HOLD/DELAY + `arm` → DELAY. Capture target, ms counter = 0, `elapsed_time` = 0. `arm` in DELAY restarts the delay with a fresh sample.
  - DELAY: increment the ms counter on each `ms_tick`. On the tick that reaches target: pulse `delay_done`, go to ARMED.
  - ARMED + `start_timer` → TIMING, `elapsed_time` = 0.
  - TIMING: `elapsed_time` +1 on each `ms_tick`.
    - On reaching `MAX_COUNT`: pulse `timeout`, go to HOLD. `best_time` is not updated.
  - TIMING + `stop_timer` → HOLD with `elapsed_time` frozen.
    - If `!best_valid` or `elapsed_time < best_time`: `best_time` ← `elapsed_time`, `best_valid` ← 1.
  - `abort` in any state → IDLE, `elapsed_time` = 0. Best time is kept.
  - `clear_best`: `best_time` ← MAX_COUNT, `best_valid` ← 0. Independent of state.
  - When `clear_best` and a best update occur in the same cycle, `clear_best` wins.
- Ignored inputs:
  - `arm` in ARMED or TIMING.
  - `start_timer` outside ARMED.
  - `stop_timer` outside TIMING.
- Priority within a cycle: `abort` > `arm` > `stop_timer` > `ms_tick`.
  - `stop_timer` coincident with `ms_tick` freezes the pre-increment value.
  - `stop_timer` coincident with the saturating tick gives a normal stop with no `timeout`.

## Timing
- Reset values:
  - state IDLE, LFSR 16'hACE1, prescaler 0, ms counter 0.
  - `elapsed_time` 0, `best_time` MAX_COUNT, `best_valid` 0.
  - `delay_done` 0, `timeout` 0, `busy` 0.
- Reset mid-trial aborts immediately and asynchronously.
- Delay latency: `arm` sampled at edge k → `delay_done` high in the cycle after edge k + target·TICKS_PER_MS.
  - Width is exactly one cycle.
  - `busy` rises the cycle after edge k.
- Counter latency: `start_timer` sampled at edge k → `elapsed_time` = n after edge k + n·TICKS_PER_MS.
- Stop latency: `stop_timer` sampled at edge k → `elapsed_time` frozen from edge k. `best_time` and `best_valid` are valid after edge k.
- All command inputs are level-sampled each cycle. No handshake or acknowledgement.

## Test plan
Bench settings: TICKS_PER_MS=4, MIN_DELAY_MS=2, MAX_COUNT=20. The bench uses an LFSR reference model.
- Reset, then `arm` → `delay_done` pulses for 1 cycle exactly (2+lfsr[10:0])·4 cycles after the arm edge; `busy`=1 throughout.
- `start_timer` in ARMED, `stop_timer` 30 cycles later → `elapsed_time`=7 frozen, `best_time`=7, `best_valid`=1.
- Second trial stopped at 9 ms → `best_time` stays 7. Third trial stopped at 3 ms → `best_time`=3.
- Never stop → `elapsed_time` climbs to 20, `timeout` pulses once, `best_time` unchanged, state HOLD.
- `abort` during DELAY → no `delay_done`, `elapsed_time`=0, `busy`=0. `arm` during DELAY → delay restarts from the new sample.
- `stop_timer` on the same cycle as `ms_tick` → pre-increment value held. `clear_best` together with a best update → `best_time`=20, `best_valid`=0. `rst_n` low mid-TIMING → all reset values immediately.
